rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the team's 8:3 encoder.
- Samples N request lines and drives a registered one-hot grant vector, which the encoder turns into a binary index.
- Guarantees the encoder only ever sees a one-hot or all-zero input, with at least one all-zero cycle between successive grants.
- A grant holds until the consumer signals done or the granted requester drops its request.

Parameters:
- N, 8, number of request lines (must be ≥2; 8 matches the downstream encoder).
- MAX_HOLD, 16, maximum grant length in cycles; used only when ARB_HOLD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  N  request lines; bit i = requester i; level-sensitive.
- done  input  1  consumer finished with the current grant; sampled only in GRANT.
- gnt  output  N  registered grant; one-hot or zero; feeds encoder inputs bit0..bitN-1.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse on forced release (optional feature); constant 0 otherwise.

Behaviour:
- Clock and reset are decided: one clock; reset is synchronous and active-low. Ports are named clk and rst_n.
- Reset (rst_n=0 at an edge): state=IDLE, gnt=0, gnt_valid=0, ptr=0, timeout=0, hold counter=0. This takes priority over everything, including mid-grant; gnt clears at that edge.
- ptr is the $clog2(N)-bit rotating priority pointer and names the highest-priority requester.
- States: IDLE, GRANT.
- IDLE:
  - If req==0: stay IDLE; outputs stay 0.
  - Else pick the first set bit of req searching upward from ptr, wrapping N-1→0. Call it index k.
  - Next edge: gnt=1<<k, gnt_valid=1, state=GRANT.
  - Latency from req sampled to gnt visible: 1 cycle.
- GRANT:
  - gnt and k are held constant.
  - Release condition: done==1 OR req[k]==0.
  - On release: gnt=0, gnt_valid=0, ptr=(k+1) mod N, state=IDLE.
  - Other req bits changing during GRANT have no effect.
- Mandatory bubble: release always passes through IDLE, so there is at least 1 zero cycle between grants. Back-to-back grants occur every ≥2 cycles.
- Simultaneous events:
  - done together with a new req: release first; the new request is arbitrated in the next IDLE cycle.
  - done together with req[k] falling: a single release.
- Wrap-around: k=N-1 releases to ptr=0.
- Fairness: with all N requesters continuously asserting and done pulsed each grant, every requester is granted once per N grants.
- Invariants:
  - $countones(gnt) ≤ 1 on every cycle.
  - gnt_valid == |gnt.
  - gnt changes only on IDLE→GRANT or GRANT→IDLE.
- X/Z on req is not a supported input; behaviour is undefined.

Optional Feature:
- Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - A $clog2(MAX_HOLD+1)-bit hold counter clears on IDLE→GRANT and increments each GRANT cycle.
  - If the counter reaches MAX_HOLD-1 with no other release, the grant is force-released on the next edge: gnt=0, ptr=k+1, timeout=1 for exactly that cycle.
  - A normal release in the same cycle takes precedence; timeout stays 0.
  - Grant length is therefore ≤ MAX_HOLD cycles.
- Not defined: no counter is built and timeout is tied 0.

Decomposition:
- Shared include arb_defs.vh:
  - State encodings ARB_IDLE=1'b0, ARB_GRANT=1'b1.
  - Default N and MAX_HOLD values.
  - A ptr-width helper macro.
- Sub-module rr_pick (combinational):
  - Inputs: req[N-1:0], ptr.
  - Outputs: one-hot pick[N-1:0] and index k.
  - Implementation: rotate right by ptr, find first set, rotate back.
- The top level holds the FSM, registers and optional counter.

Test Plan:
- Reset mid-grant: grant req=8'b0000_0100, then drive rst_n=0 for one edge → gnt=0, gnt_valid=0, ptr=0 after that edge.
- Single request: req=8'b0001_0000 from IDLE → gnt=8'b0001_0000 one cycle later; req drops → gnt=0 the next edge; ptr=5.
- Rotation: req=8'hFF held, done pulsed once per grant → grants in order bit0,1,…,7,0 with exactly one zero cycle between grants.
- Wrap/priority: ptr=6 with req=8'b1000_0011 → grant bit7; then after release, with the same req → grant bit0.
- Simultaneous: req=8'b0000_0110 granted bit1; done=1 in the same cycle req[1] falls → one release; next grant bit2 after the IDLE cycle.
- Timeout (macro defined, MAX_HOLD=4): req=8'b0000_1000 held, done=0 → gnt high 4 cycles, then gnt=0 with timeout=1 for 1 cycle; same stimulus without macro → gnt stays held and timeout stays 0.

Source files
------------

// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: FSM state encoding,
// default sizing and the pointer-width helper.
package rr_onehot_arbiter_pkg;

    localparam int unsigned ARB_N_DEF        = 8;
    localparam int unsigned ARB_MAX_HOLD_DEF = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Width of an index/pointer into N request lines (at least 1 bit).
    function automatic int unsigned arb_ptr_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req right by ptr, find the first set
// bit, rotate the result back into a one-hot pick and its binary index.
module rr_pick
    import rr_onehot_arbiter_pkg::*;
#(
    parameter int unsigned N  = ARB_N_DEF,
    parameter int unsigned PW = arb_ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx
);

    logic [N-1:0] rot;
    logic         found;
    int unsigned  off;
    int unsigned  src;
    int unsigned  sum;

    always_comb begin
        rot   = '0;
        found = 1'b0;
        off   = 0;
        src   = 0;
        sum   = 0;
        // rot[i] holds the requester i places above ptr (wrapping)
        for (int unsigned i = 0; i < N; i++) begin
            src = i + 32'(ptr);
            if (src >= N) src = src - N;
            rot[PW'(i)] = req[PW'(src)];
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rot[PW'(i)]) begin
                found = 1'b1;
                off   = i;
            end
        end
        sum = off + 32'(ptr);
        if (sum >= N) sum = sum - N;
        idx  = PW'(sum);
        pick = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter driving a registered one-hot grant into the 8:3 encoder,
// with a forced idle cycle between grants. Define ARB_HOLD_TIMEOUT_EN to cap grants at MAX_HOLD cycles.
module rr_onehot_arbiter
    import rr_onehot_arbiter_pkg::*;
#(
    parameter int unsigned N        = ARB_N_DEF,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic         timeout
);

    localparam int unsigned PW = arb_ptr_w(N);

    if (N < 2) begin : g_bad_n
        $error("rr_onehot_arbiter: N must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("rr_onehot_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] k_q;
    logic [PW-1:0] k_d;
    logic [N-1:0]  gnt_d;
    logic          timeout_d;
    logic [N-1:0]  pick_c;
    logic [PW-1:0] pick_idx_c;
    logic          release_c;
    logic          force_c;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick_c),
        .idx  (pick_idx_c)
    );

    assign release_c = done | ~req[k_q];

`ifdef ARB_HOLD_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;

    // Counts cycles the current grant has been visible; zero while idle.
    assign hold_d  = (state_q == ARB_GRANT) ? hold_q + HW'(1) : '0;
    assign force_c = (state_q == ARB_GRANT) && !release_c && (hold_q == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q  <= '0;
            timeout <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            timeout <= timeout_d;
        end
    end
`else
    assign force_c = 1'b0;
    assign timeout = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            gnt_valid <= |gnt_d;
            ptr       <= ptr_d;
            k_q       <= k_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (|req)                state_d = ARB_GRANT;
            ARB_GRANT: if (release_c || force_c) state_d = ARB_IDLE;
            default:                            state_d = ARB_IDLE;
        endcase
    end

    // Next grant, pointer and timeout pulse
    always_comb begin
        gnt_d     = gnt;
        ptr_d     = ptr;
        k_d       = k_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    gnt_d = pick_c;
                    k_d   = pick_idx_c;
                end
            end
            ARB_GRANT: begin
                if (release_c || force_c) begin
                    gnt_d     = '0;
                    ptr_d     = (k_q == PW'(N - 1)) ? '0 : k_q + PW'(1);
                    timeout_d = force_c;
                end
            end
            default: gnt_d = '0;
        endcase
    end

`ifndef ARB_HOLD_TIMEOUT_EN
    logic unused_timeout_d;
    assign unused_timeout_d = timeout_d;
`endif

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: integer round-robin model checked
// every cycle plus directed scenarios with hand-computed expectations.
module tb_rr_onehot_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    rr_onehot_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the grant, whose turn is next, how long held.
    bit           started = 1'b0;
    bit           m_busy  = 1'b0;
    int           m_k     = 0;
    int           m_ptr   = 0;
    int           m_hold  = 0;
    logic [N-1:0] exp_gnt = '0;
    logic         exp_to  = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        exp_to  = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_k = 0; m_ptr = 0; m_hold = 0; exp_gnt = '0;
        end else if (!m_busy) begin
            if (req != '0) begin
                for (int d = 0; d < N; d++) begin
                    if (req[(m_ptr + d) % N]) begin
                        m_k = (m_ptr + d) % N;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_hold  = 0;
                exp_gnt = '0;
                exp_gnt[m_k] = 1'b1;
            end
        end else begin
            if (done || !req[m_k] || (TO_EN && m_hold == MAX_HOLD - 1)) begin
                exp_to  = !(done || !req[m_k]);
                m_busy  = 1'b0;
                m_ptr   = (m_k + 1) % N;
                exp_gnt = '0;
            end else begin
                m_hold++;
            end
        end
    end

    // Per-cycle comparison against the model and the output invariants.
    always @(negedge clk) begin
        if (started) begin
            check("model_gnt", 32'(gnt), 32'(exp_gnt));
            check("model_valid", 32'(gnt_valid), 32'(exp_gnt != '0));
            check("model_timeout", 32'(timeout), 32'(exp_to));
            check("model_ptr", 32'(dut.ptr), 32'(m_ptr));
            check("onehot_gnt", 32'($countones(gnt) <= 1), 32'd1);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; done = 1'b0;
        cyc(); cyc();
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_valid", 32'(gnt_valid), 32'h0);
        check("reset_ptr", 32'(dut.ptr), 32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;

        // Reset mid-grant
        req = 8'b0000_0100;
        cyc();
        check("midrst_grant", 32'(gnt), 32'h04);
        rst_n = 1'b0;
        cyc();
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_valid", 32'(gnt_valid), 32'h0);
        check("midrst_ptr", 32'(dut.ptr), 32'h0);
        rst_n = 1'b1; req = '0;
        cyc();

        // Single request, released by dropping req
        req = 8'b0001_0000;
        cyc();
        check("single_gnt", 32'(gnt), 32'h10);
        check("single_valid", 32'(gnt_valid), 32'h1);
        req = '0;
        cyc();
        check("single_rel", 32'(gnt), 32'h0);
        check("single_ptr", 32'(dut.ptr), 32'd5);
        check("single_mptr", 32'(m_ptr), 32'd5);

        // Rotation from ptr=0 with all requesters asserting
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            cyc();
            check("rot_gnt", 32'(gnt), 32'(1) << (g % 8));
            done = 1'b1;
            cyc();
            check("rot_bubble", 32'(gnt), 32'h0);
            done = 1'b0;
        end
        req = '0;
        cyc();
        check("rot_ptr", 32'(dut.ptr), 32'd1);

        // Move ptr to 6, then wrap priority
        req = 8'b0010_0000;
        cyc();
        check("wrap_setup", 32'(gnt), 32'h20);
        req = '0;
        cyc();
        check("wrap_ptr6", 32'(dut.ptr), 32'd6);
        req = 8'b1000_0011;
        cyc();
        check("wrap_gnt7", 32'(gnt), 32'h80);
        done = 1'b1;
        cyc();
        check("wrap_rel", 32'(gnt), 32'h0);
        check("wrap_ptr0", 32'(dut.ptr), 32'd0);
        done = 1'b0;
        cyc();
        check("wrap_gnt0", 32'(gnt), 32'h01);
        req = '0;
        cyc();
        check("wrap_ptr1", 32'(dut.ptr), 32'd1);

        // done and req[k] falling together: single release
        req = 8'b0000_0110;
        cyc();
        check("simul_gnt1", 32'(gnt), 32'h02);
        done = 1'b1; req = 8'b0000_0100;
        cyc();
        check("simul_rel", 32'(gnt), 32'h0);
        check("simul_ptr", 32'(dut.ptr), 32'd2);
        done = 1'b0;
        cyc();
        check("simul_gnt2", 32'(gnt), 32'h04);
        req = '0;
        cyc();
        check("simul_ptr3", 32'(dut.ptr), 32'd3);

        // Held request with no done
        req = 8'b0000_1000;
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("hold_gnt", 32'(gnt), 32'h08);
            check("hold_to", 32'(timeout), 32'h0);
        end
        cyc();
        if (TO_EN) begin
            check("to_gnt", 32'(gnt), 32'h0);
            check("to_pulse", 32'(timeout), 32'h1);
            cyc();
            check("to_pulse_end", 32'(timeout), 32'h0);
            check("to_regrant", 32'(gnt), 32'h08);
        end else begin
            check("noto_gnt", 32'(gnt), 32'h08);
            check("noto_to", 32'(timeout), 32'h0);
            cyc();
            check("noto_gnt2", 32'(gnt), 32'h08);
        end
        req = '0;
        cyc(); cyc();
        check("end_idle", 32'(gnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
